// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The producer/consumer side uses master; the adder uses slave.
interface pipe_adder_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         c_in;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] z;
   logic         c_out;
   logic         ovf;

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, z, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, z, c_out, ovf
   );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined carry-propagate adder/subtractor, one W=N/S-bit chunk per stage.
// Optional feature macro: PIPE_ADDER_OVF_EN builds the registered signed-overflow output.
module pipe_adder #(
   parameter int N = 32,
   parameter int S = 4
) (
   input logic         clk,
   input logic         rst,
   pipe_adder_if.slave bus
);
   localparam int W = N / S;

   logic [S-1:0] v_q;
   logic [S-1:0] v_d;
   logic         en_s;
   logic         acc_s;

   // A full, unconsumed last stage freezes every stage at once.
   assign en_s         = !v_q[S-1] || bus.out_ready;
   assign bus.in_ready = en_s && !rst;
   assign acc_s        = bus.in_valid && bus.in_ready;

   // Valid-bit shift; bubbles are kept in place during a stall.
   always_comb begin
      v_d = v_q;
      if (en_s) begin
         v_d[0] = acc_s;
         for (int k = 1; k < S; k++) begin
            v_d[k] = v_q[k-1];
         end
      end else begin
         v_d = v_q;
      end
   end

   // Valid-bit register.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
      end else begin
         v_q <= v_d;
      end
   end

   for (genvar k = 0; k < S; k++) begin : g_st
      localparam int OW = (S - k) * W;
      localparam int RW = (k + 1) * W;

      logic [OW-1:0] a_s;
      logic [OW-1:0] b_s;
      logic          cy_s;
      logic [W:0]    sum_s;
      logic [RW-1:0] r_d;
      logic [RW-1:0] r_q;
      logic          cy_d;
      logic          cy_q;

      // Stage 0 works straight off the bus; later stages off the skew/deskew registers.
      if (k == 0) begin : g_first
         assign a_s  = bus.a;
         assign b_s  = bus.b ^ {N{bus.sub}};
         assign cy_s = bus.c_in;
         assign r_d  = sum_s[W-1:0];
      end else begin : g_next
         assign a_s  = g_st[k-1].g_fwd.a_q;
         assign b_s  = g_st[k-1].g_fwd.b_q;
         assign cy_s = g_st[k-1].cy_q;
         assign r_d  = {sum_s[W-1:0], g_st[k-1].r_q};
      end

      assign sum_s = {1'b0, a_s[W-1:0]} + {1'b0, b_s[W-1:0]} + {{W{1'b0}}, cy_s};
      assign cy_d  = sum_s[W];

      // Result chunk and chunk carry register.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_q  <= '0;
            cy_q <= 1'b0;
         end else if (en_s) begin
            r_q  <= r_d;
            cy_q <= cy_d;
         end
      end

      if (k < S - 1) begin : g_fwd
         logic [OW-W-1:0] a_q;
         logic [OW-W-1:0] b_q;

         // Upper operand chunks ride along until their stage.
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en_s) begin
               a_q <= a_s[OW-1:W];
               b_q <= b_s[OW-1:W];
            end
         end
      end
   end

   assign bus.out_valid = v_q[S-1];
   assign bus.z         = g_st[S-1].r_q;
   assign bus.c_out     = g_st[S-1].cy_q;

`ifdef PIPE_ADDER_OVF_EN
   logic ovf_q;
   logic ovf_d;
   logic msb_cin_s;

   // Carry into the MSB recovered from its sum bit: cin = a ^ b ^ s.
   assign msb_cin_s = g_st[S-1].a_s[W-1] ^ g_st[S-1].b_s[W-1] ^ g_st[S-1].sum_s[W-1];
   assign ovf_d     = msb_cin_s ^ g_st[S-1].sum_s[W];

   // Overflow flag registered alongside the last result chunk.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (en_s) begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// Directed/random self-checking bench for pipe_adder (N=32,S=4 and N=8,S=1).
// Expected ovf follows PIPE_ADDER_OVF_EN.
module tb_pipe_adder;
   typedef struct packed {
      logic [31:0] z;
      logic        c;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   exp_t e;
   logic ovf_exp;
   bit   seen;
   int   n_seen;
   int   sent;
   int   first_cyc;
   int   last_cyc;

   pipe_adder_if #(.N(32)) u_if ();
   pipe_adder_if #(.N(8))  u8_if ();

   pipe_adder #(.N(32), .S(4)) u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));
   pipe_adder #(.N(8),  .S(1)) u_dut8 (.clk(clk), .rst(rst), .bus(u8_if.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input logic sb);
      exp_t        r;
      logic [31:0] bb;
      logic [32:0] s;
      bb  = sb ? ~b : b;
      s   = {1'b0, a} + {1'b0, bb} + {32'd0, ci};
      r.z = s[31:0];
      r.c = s[32];
`ifdef PIPE_ADDER_OVF_EN
      r.ovf = (a[31] == bb[31]) && (s[31] != a[31]);
`else
      r.ovf = 1'b0;
`endif
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb);
      u_if.in_valid = v;
      u_if.a        = a;
      u_if.b        = b;
      u_if.c_in     = ci;
      u_if.sub      = sb;
   endtask

   // One clock: account for accept/pop, then check the visible output against the scoreboard.
   task automatic step(output bit vis);
      bit acc;
      bit pop;
      #1;
      acc = u_if.in_valid && u_if.in_ready;
      pop = u_if.out_valid && u_if.out_ready;
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(model(u_if.a, u_if.b, u_if.c_in, u_if.sub));
      tick();
      vis = u_if.out_valid;
      if (exp_q.size() == 0) begin
         check("no_spurious_out", {63'd0, u_if.out_valid}, 64'd0);
      end else if (u_if.out_valid) begin
         check("stream_z", {32'd0, u_if.z}, {32'd0, exp_q[0].z});
         check("stream_cout", {63'd0, u_if.c_out}, {63'd0, exp_q[0].c});
         check("stream_ovf", {63'd0, u_if.ovf}, {63'd0, exp_q[0].ovf});
      end
   endtask

   initial begin
`ifdef PIPE_ADDER_OVF_EN
      ovf_exp = 1'b1;
`else
      ovf_exp = 1'b0;
`endif
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      u_if.out_ready  = 1'b1;
      u8_if.in_valid  = 1'b0;
      u8_if.a         = 8'd0;
      u8_if.b         = 8'd0;
      u8_if.c_in      = 1'b0;
      u8_if.sub       = 1'b0;
      u8_if.out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_in_ready", {63'd0, u_if.in_ready}, 64'd0);
      check("rst_out_valid", {63'd0, u_if.out_valid}, 64'd0);
      check("rst_z", {32'd0, u_if.z}, 64'd0);
      check("rst_cout", {63'd0, u_if.c_out}, 64'd0);
      check("rst_ovf", {63'd0, u_if.ovf}, 64'd0);
      check("rst8_out_valid", {63'd0, u8_if.out_valid}, 64'd0);
      check("rst8_z", {56'd0, u8_if.z}, 64'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {63'd0, u_if.in_ready}, 64'd1);

      // Carry ripple through all four stages, latency 4 edges
      drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      check("lat_e1", {63'd0, u_if.out_valid}, 64'd0);
      tick();
      check("lat_e2", {63'd0, u_if.out_valid}, 64'd0);
      tick();
      check("lat_e3", {63'd0, u_if.out_valid}, 64'd0);
      tick();
      check("lat_e4", {63'd0, u_if.out_valid}, 64'd1);
      check("ripple_z", {32'd0, u_if.z}, 64'h0000_0000);
      check("ripple_cout", {63'd0, u_if.c_out}, 64'd1);
      check("ripple_ovf", {63'd0, u_if.ovf}, 64'd0);
      tick();
      check("ripple_done", {63'd0, u_if.out_valid}, 64'd0);

      // Subtract: 5-7 borrows; 0x8000_0000-1 overflows signed
      drive(1'b1, 32'd5, 32'd7, 1'b1, 1'b1);
      tick();
      drive(1'b1, 32'h8000_0000, 32'd1, 1'b1, 1'b1);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      tick();
      check("sub1_valid", {63'd0, u_if.out_valid}, 64'd1);
      check("sub1_z", {32'd0, u_if.z}, 64'hFFFF_FFFE);
      check("sub1_cout", {63'd0, u_if.c_out}, 64'd0);
      check("sub1_ovf", {63'd0, u_if.ovf}, 64'd0);
      tick();
      check("sub2_valid", {63'd0, u_if.out_valid}, 64'd1);
      check("sub2_z", {32'd0, u_if.z}, 64'h7FFF_FFFF);
      check("sub2_cout", {63'd0, u_if.c_out}, 64'd1);
      check("sub2_ovf", {63'd0, u_if.ovf}, {63'd0, ovf_exp});
      tick();
      check("sub_done", {63'd0, u_if.out_valid}, 64'd0);

      // 100 random back-to-back beats
      sent = 0; n_seen = 0; first_cyc = -1; last_cyc = -1;
      for (int cyc = 0; cyc < 300 && (sent < 100 || exp_q.size() > 0); cyc++) begin
         if (sent < 100) begin
            drive(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (u_if.in_ready) sent++;
         end else begin
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
         end
         step(seen);
         if (seen) begin
            n_seen++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
      end
      check("stream_sent", 64'(sent), 64'd100);
      check("stream_results", 64'(n_seen), 64'd100);
      check("stream_no_gaps", 64'(last_cyc - first_cyc), 64'd99);

      // Fill the pipe, stall 10 cycles, then pop/push together while full
      u_if.out_ready = 1'b0;
      drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0); step(seen);
      drive(1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0); step(seen);
      drive(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1); step(seen);
      drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); step(seen);
      drive(1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0);
      #1;
      check("full_in_ready", {63'd0, u_if.in_ready}, 64'd0);
      for (int i = 0; i < 10; i++) begin
         step(seen);
         check("stall_in_ready", {63'd0, u_if.in_ready}, 64'd0);
         check("stall_out_valid", {63'd0, u_if.out_valid}, 64'd1);
      end
      check("stall_z_first", {32'd0, u_if.z}, 64'h2345_6789);
      u_if.out_ready = 1'b1;
      n_seen = 0;
      step(seen);
      if (seen) n_seen++;
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(seen);
         if (seen) n_seen++;
      end
      check("drain_count", 64'(n_seen), 64'd4);
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset with three beats in flight
      drive(1'b1, 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0); step(seen);
      drive(1'b1, 32'h0000_0300, 32'h0000_0400, 1'b0, 1'b0); step(seen);
      drive(1'b1, 32'h0000_0500, 32'h0000_0600, 1'b0, 1'b0); step(seen);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", {63'd0, u_if.in_ready}, 64'd0);
      tick();
      check("mid_rst_out_valid", {63'd0, u_if.out_valid}, 64'd0);
      check("mid_rst_z", {32'd0, u_if.z}, 64'd0);
      check("mid_rst_cout", {63'd0, u_if.c_out}, 64'd0);
      exp_q.delete();
      rst = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(seen);

      // S=1: single registered full-width add
      u8_if.a        = 8'h80;
      u8_if.b        = 8'h80;
      u8_if.c_in     = 1'b1;
      u8_if.sub      = 1'b0;
      u8_if.in_valid = 1'b1;
      #1;
      check("s1_in_ready", {63'd0, u8_if.in_ready}, 64'd1);
      tick();
      u8_if.in_valid = 1'b0;
      check("s1_valid", {63'd0, u8_if.out_valid}, 64'd1);
      check("s1_z", {56'd0, u8_if.z}, 64'h01);
      check("s1_cout", {63'd0, u8_if.c_out}, 64'd1);
      check("s1_ovf", {63'd0, u8_if.ovf}, {63'd0, ovf_exp});
      tick();
      check("s1_done", {63'd0, u8_if.out_valid}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined carry-propagate adder/subtractor with valid/ready handshakes on both sides. It splits an N-bit operation into S chunks of N/S bits, one chunk per pipeline stage, and registers the inter-chunk carry between stages. It is the clocked successor to the team's combinational carry-lookahead adder, for datapaths where a full-width single-cycle add misses timing. It sits between operand producers and result consumers that can apply backpressure.

## Interface
Parameters:
- N, 32: operand and result width; must be a multiple of S.
- S, 4: pipeline stage count, ≥1; chunk width W = N/S.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- c_in  in  1  carry into bit 0.
- sub  in  1  1: compute a + ~b + c_in; 0: compute a + b + c_in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result this cycle.
- z  out  N  sum/difference.
- c_out  out  1  carry out of bit N-1.
- ovf  out  1  signed overflow (see Configuration).

## Operation
- Beat accepted when in_valid && in_ready at a rising edge; captures a, b^{N{sub}}, c_in, sub.
- Stage k (0..S-1) adds chunk k, bits [k·W+W-1 : k·W], of the two operands with the carry registered by stage k-1 (stage 0 uses captured c_in). Stage k registers its W-bit result chunk and its carry-out.
- Upper operand chunks travel through skew registers so that chunk k reaches stage k together with carry k. Lower result chunks travel through deskew registers so that all N result bits and c_out present together at the output.
- Arithmetic is modulo 2^N. c_out is the true carry out of bit N-1. With sub=1 and c_in=1, c_out=1 means no borrow (a ≥ b unsigned).
- Each stage holds a valid bit v[k]. The global enable is en = !v[S-1] || out_ready. When en=1, all stages shift one position: v[0] ← in_valid && in_ready, and v[k] ← v[k-1].
- in_ready = en && !rst. Bubbles inside the pipe are not collapsed during a stall.
- out_valid = v[S-1]. z, c_out and ovf hold stable while out_valid && !out_ready.
- Reset clears all v[k] and zeroes z, c_out and ovf. In-flight beats are discarded, not flushed.
- S=1 degenerates to one registered full-width add.

## Timing
- Reset values: out_valid=0, z=0, c_out=0, ovf=0. in_ready=0 during rst and 1 in the first cycle after rst deasserts.
- Latency: a beat accepted at edge t shows out_valid=1 after edge t+S-1, i.e. it is visible in the cycle following S accepting edges. For S=1 the result is visible in the cycle right after acceptance.
- Throughput: one beat per cycle while out_ready=1.
- Simultaneous output pop and input push in the same cycle with the pipe full is legal and loses no beat.
- out_ready=0 with v[S-1]=1 stalls the whole pipe and drops in_ready the same cycle (combinational path out_ready → in_ready).
- rst asserted mid-stream: at the next edge all valids are 0. No output beat follows until a new beat is accepted after reset.

## Configuration
- PIPE_ADDER_OVF_EN defined: ovf = carry into bit N-1 XOR c_out, registered alongside z (two's-complement overflow of the add or subtract).
- Not defined: the ovf port is still present, tied to 0; no extra registers are built.

## Test plan
- N=32, S=4, out_ready=1, a=0xFFFF_FFFF, b=1, c_in=0, sub=0 → z=0x0000_0000, c_out=1, result appears 4 edges after accept. Exercises the carry ripple across all stages.
- sub=1, c_in=1, a=5, b=7 → z=0xFFFF_FFFE, c_out=0. With PIPE_ADDER_OVF_EN: a=0x8000_0000, b=1 → z=0x7FFF_FFFF, ovf=1.
- Back-to-back stream of 100 random beats with out_ready=1 → one result per cycle, in order, each matching (a ± b + c_in) mod 2^32.
- Fill the pipe, then hold out_ready=0 for 10 cycles → in_ready=0, z/c_out stable. On release, 4 results drain in order with no loss or duplication.
- Assert rst for 1 cycle with 3 beats in flight → out_valid=0 and z=0 next cycle. None of the 3 beats ever emerges.
- N=8, S=1: a=0x80, b=0x80, c_in=1 → z=0x01, c_out=1, result visible in the cycle after acceptance.
